// File: rtl/cpu_pkg.sv
// Shared pipeline-control definitions: FSM encoding, hold/clear bit positions
// and the canned enb/flash patterns built from them.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    localparam int TIMEOUT_DEF = 255;

    // enb = {M,E,D,F}
    localparam int ENB_F = 0;
    localparam int ENB_D = 1;
    localparam int ENB_E = 2;
    localparam int ENB_M = 3;

    // flash = {W,M,E,D}
    localparam int FL_D = 0;
    localparam int FL_E = 1;
    localparam int FL_M = 2;
    localparam int FL_W = 3;

    localparam logic [3:0] ENB_NONE    = 4'b0000;
    localparam logic [3:0] ENB_MEM     = 4'(1 << ENB_M) | 4'(1 << ENB_E) | 4'(1 << ENB_D) | 4'(1 << ENB_F);
    localparam logic [3:0] ENB_LU      = 4'(1 << ENB_D) | 4'(1 << ENB_F);
    localparam logic [3:0] ENB_FETCH   = 4'(1 << ENB_F);

    localparam logic [3:0] FLASH_NONE  = 4'b0000;
    localparam logic [3:0] FLASH_ALL   = 4'b1111;
    localparam logic [3:0] FLASH_MEM   = 4'(1 << FL_W);
    localparam logic [3:0] FLASH_BRCH  = 4'(1 << FL_M) | 4'(1 << FL_E) | 4'(1 << FL_D);
    localparam logic [3:0] FLASH_LU    = 4'(1 << FL_E);
    localparam logic [3:0] FLASH_FETCH = 4'(1 << FL_D);

endpackage

// File: rtl/lu_detect.sv
// Load-use hazard comparator: a load in EX whose destination feeds a decode source.
module lu_detect (
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rdE,
    input  logic       loadE,
    output logic       hazard
);

    // r0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign hazard = loadE && (rdE != 5'd0) && ((rdE == rsD) || (rdE == rtD));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: memory-wait stall with timeout, branch flush,
// load-use stall and fetch wait, plus a saturating stalled-cycle counter.
//
// state       | meaning
// ST_RUN      | normal issue; hazards resolved combinationally each cycle
// ST_MEM_WAIT | data access outstanding; whole pipe held, WB bubbled
// ST_ERR      | data access timed out; pipe frozen until rst
module pipe_ctrl
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rdE,
    input  logic             loadE,
    input  logic             brch_takenM,
    input  logic             dmem_reqM,
    input  logic             dmem_ack,
    input  logic             imem_ack,
    output logic [3:0]       enb,
    output logic [3:0]       flash,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic                w_hazard;
    logic                w_mem_stall;

    lu_detect u_lu_detect (
        .rsD    (rsD),
        .rtD    (rtD),
        .rdE    (rdE),
        .loadE  (loadE),
        .hazard (w_hazard)
    );

    assign w_mem_stall = dmem_reqM && !dmem_ack;

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        enb         = ENB_NONE;
        flash       = FLASH_NONE;
        if (rst) begin
            flash = FLASH_ALL;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_stall) begin
                        enb         = ENB_MEM;
                        flash       = FLASH_MEM;
                        w_state_nxt = ST_MEM_WAIT;
                        w_wait_nxt  = '0;
                    end else if (brch_takenM) begin
                        flash = FLASH_BRCH;
                    end else if (w_hazard) begin
                        enb   = ENB_LU;
                        flash = FLASH_LU;
                    end else if (!imem_ack) begin
                        enb   = ENB_FETCH;
                        flash = FLASH_FETCH;
                    end
                end
                ST_MEM_WAIT: begin
                    enb   = ENB_MEM;
                    flash = FLASH_MEM;
                    // The ack cycle itself is still held; RUN resumes next cycle.
                    if (dmem_ack) begin
                        w_state_nxt = ST_RUN;
                    end else if (r_wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        w_state_nxt = ST_ERR;
                    end else begin
                        w_wait_nxt = r_wait_cnt + WAIT_W'(1);
                    end
                end
                ST_ERR: begin
                    enb   = ENB_MEM;
                    flash = FLASH_MEM;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if ((|enb) && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign err       = (r_state == ST_ERR) && !rst;
    assign stall_cnt = r_stall_cnt;

endmodule
